// File: rtl/cl_capture_ctrl_pkg.sv
// Shared definitions for the Camera Link capture sequencer: state encoding,
// command bit positions and status word layout.
package cl_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2
  } state_e;

  localparam int CMD_CONT  = 31;
  localparam int CMD_ABORT = 30;

  localparam int STAT_STATE_LSB = 29;
  localparam int STAT_OVF       = 28;
  localparam int STAT_REJ       = 27;
  localparam int STAT_DONE_LSB  = 14;
  localparam int STAT_DONE_W    = 12;
  localparam int STAT_LINES_LSB = 0;
  localparam int STAT_LINES_W   = 14;

  function automatic logic [31:0] pack_status(
    input state_e                  st,
    input logic                    ovf,
    input logic                    rej,
    input logic [STAT_DONE_W-1:0]  done,
    input logic [STAT_LINES_W-1:0] lines
  );
    logic [31:0] s;
    s                                  = '0;
    s[STAT_STATE_LSB +: 3]             = st;
    s[STAT_OVF]                        = ovf;
    s[STAT_REJ]                        = rej;
    s[STAT_DONE_LSB +: STAT_DONE_W]    = done;
    s[STAT_LINES_LSB +: STAT_LINES_W]  = lines;
    return s;
  endfunction

endpackage

// File: rtl/cl_edge_det.sv
// Registered edge detector: keeps a one-cycle-old copy of the input and
// flags rise/fall combinationally against it.
module cl_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/cl_capture_ctrl.sv
// Host-driven frame-capture sequencer: arms on command, captures whole frames
// aligned to FVAL, gates pixel writes and reports progress in a status word.
module cl_capture_ctrl
  import cl_capture_ctrl_pkg::*;
#(
  parameter int FRAME_CNT_W = 16,
  parameter int LINE_CNT_W  = 16,
  parameter int DONE_CNT_W  = 12
) (
  input  logic        bus_clk,
  input  logic        reset_n,
  input  logic        cl_fval,
  input  logic        cl_lval,
  input  logic        wr_32_wren,
  input  logic [31:0] wr_32_data,
  input  logic        fifo_full,
  output logic        capture_en,
  output logic        frame_start,
  output logic        frame_end,
  output logic        busy,
  output logic [31:0] status
);

  state_e                  state_q, state_d;
  logic [FRAME_CNT_W-1:0]  rem_q, rem_d;
  logic                    cont_q, cont_d;
  logic                    drop_q, drop_d;
  logic                    ovf_q, ovf_d;
  logic                    rej_q, rej_d;
  logic [LINE_CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [STAT_LINES_W-1:0] lines_last_q, lines_last_d;
  logic [DONE_CNT_W-1:0]   frames_done_q, frames_done_d;
  logic                    fs_q, fs_d;
  logic                    fe_q, fe_d;

  logic fval_rise, fval_fall, lval_fall, lval_rise_unused;
  logic cmd_abort, cmd_cont, ovf_now;
  logic [FRAME_CNT_W-1:0] cmd_n;
  logic [29:FRAME_CNT_W]  cmd_unused;

  cl_edge_det u_fval_edge (
    .clk_i  (bus_clk),
    .rst_ni (reset_n),
    .d_i    (cl_fval),
    .rise_o (fval_rise),
    .fall_o (fval_fall)
  );

  cl_edge_det u_lval_edge (
    .clk_i  (bus_clk),
    .rst_ni (reset_n),
    .d_i    (cl_lval),
    .rise_o (lval_rise_unused),
    .fall_o (lval_fall)
  );

  assign cmd_abort  = wr_32_wren & wr_32_data[CMD_ABORT];
  assign cmd_cont   = wr_32_data[CMD_CONT];
  assign cmd_n      = wr_32_data[FRAME_CNT_W-1:0];
  assign cmd_unused = wr_32_data[29:FRAME_CNT_W];
  assign ovf_now    = (state_q == ST_CAPTURE) & cl_lval & fifo_full;

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    cont_d        = cont_q;
    drop_d        = drop_q;
    ovf_d         = ovf_q;
    rej_d         = rej_q;
    line_cnt_d    = line_cnt_q;
    lines_last_d  = lines_last_q;
    frames_done_d = frames_done_q;
    fs_d          = 1'b0;
    fe_d          = 1'b0;

    // Abort beats everything, including a coincident FVAL fall.
    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else begin
      if (wr_32_wren && state_q != ST_IDLE) rej_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (wr_32_wren && (cmd_n != '0 || cmd_cont)) begin
            rem_d         = cmd_n;
            cont_d        = cmd_cont;
            frames_done_d = '0;
            ovf_d         = 1'b0;
            rej_d         = 1'b0;
            state_d       = ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Only a fresh rise starts capture, so a frame in progress is skipped.
          if (fval_rise) begin
            state_d    = ST_CAPTURE;
            fs_d       = 1'b1;
            line_cnt_d = '0;
            drop_d     = 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (ovf_now) begin
            ovf_d  = 1'b1;
            drop_d = 1'b1;
          end
          if (lval_fall && line_cnt_q != '1) line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
          if (fval_fall) begin
            lines_last_d  = line_cnt_q[STAT_LINES_W-1:0];
            frames_done_d = frames_done_q + DONE_CNT_W'(1);
            fe_d          = 1'b1;
            if (drop_q || ovf_now) begin
              state_d = ST_IDLE;
            end else if (cont_q) begin
              state_d = ST_ARMED;
            end else begin
              rem_d   = rem_q - FRAME_CNT_W'(1);
              state_d = (rem_q == FRAME_CNT_W'(1)) ? ST_IDLE : ST_ARMED;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      cont_q        <= 1'b0;
      drop_q        <= 1'b0;
      ovf_q         <= 1'b0;
      rej_q         <= 1'b0;
      line_cnt_q    <= '0;
      lines_last_q  <= '0;
      frames_done_q <= '0;
      fs_q          <= 1'b0;
      fe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      cont_q        <= cont_d;
      drop_q        <= drop_d;
      ovf_q         <= ovf_d;
      rej_q         <= rej_d;
      line_cnt_q    <= line_cnt_d;
      lines_last_q  <= lines_last_d;
      frames_done_q <= frames_done_d;
      fs_q          <= fs_d;
      fe_q          <= fe_d;
    end
  end

  // Zero-latency gate; state_q resets asynchronously so this drops with reset_n.
  assign capture_en  = (state_q == ST_CAPTURE) & cl_lval & ~fifo_full & ~drop_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign busy        = (state_q != ST_IDLE);
  assign status      = pack_status(state_q, ovf_q, rej_q,
                                   STAT_DONE_W'(frames_done_q), lines_last_q);

endmodule
